pcs_am_insert: RTL and testbench
================================

# pcs_am_insert

Parametrised multi-lane alignment-marker inserter for the PCS transmit path, sitting between the per-lane 64b/66b encoder/scrambler output and the PMA gearbox. Every `AM_PERIOD` data blocks it stalls the upstream encoder for one cycle and inserts an IEEE 802.3 Clause 82 alignment marker on all lanes simultaneously. Each marker optionally carries a per-lane BIP3/BIP7 parity. `LANE_N` covers the 40G case (4) and the 100G case (20) with the same RTL.

## Interface
- `LANE_N`, 4, number of PCS lanes; legal range 1..20.
- `AM_PERIOD`, 16383, data blocks per lane between markers; minimum 2.
- `clk`  in  1  single clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `head_i`  in  `2*LANE_N`  per-lane 66b sync header; lane x at `[2x+1:2x]`.
- `data_i`  in  `64*LANE_N`  per-lane scrambled block payload; lane x at `[64x+63:64x]`.
- `ready_o`  out  1  inputs are consumed this cycle when high.
- `head_o`  out  `2*LANE_N`  per-lane sync header to the gearbox.
- `data_o`  out  `64*LANE_N`  per-lane payload to the gearbox.
- `am_v_o`  out  1  the current output cycle is an alignment marker on all lanes.

## Operation
- No upstream valid signal. The encoder presents a block every cycle and holds it while `ready_o`=0.
- Cycle counter `cnt` runs over 0..`AM_PERIOD`. The width is `$clog2(AM_PERIOD+1)`. It increments every cycle and wraps `AM_PERIOD`→0.
- `ready_o` = (`cnt` != 0). It is decoded from the registered `cnt` with no input path.
- When `cnt`==0 the next output is a marker. Otherwise the next output is `head_i`/`data_i` passed through unchanged.
- Marker on lane x:
  - `head_o` = 2'b10.
  - Payload octets 0..7 = M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3.
  - Octet 0 occupies bits [7:0].
  - M0..M2 come from the Clause 82 lane-marker table for lane x.
- BIP3 for lane x covers every 66b block output on lane x since the previous marker, including that previous marker and excluding the current one.
- BIP3 bit mapping, with 66b bit j numbered so that j=0 is the first header bit:
  - j=0 → bit 3.
  - j=1 → bit 4.
  - j≥2 → bit (j−2) mod 8.
- On a marker cycle the accumulator is reloaded with the parity of the marker just sent. On a data cycle it XORs in the data block's parity.
- The first marker after reset carries BIP3=8'h00.

## Timing
- Reset values:
  - `cnt`=0, so `ready_o`=0.
  - `head_o`=0, `data_o`=0, `am_v_o`=0.
  - All BIP accumulators = 0.
- Latency is one cycle. Inputs sampled at edge n with `ready_o`=1 appear on the outputs after edge n.
- A cycle n with `ready_o`=0 produces a marker on the outputs after edge n, with `am_v_o`=1 for exactly that output cycle.
- First output after reset release is a marker. Then come `AM_PERIOD` data cycles, then a marker, and so on. The period is `AM_PERIOD+1` cycles.
- Reset asserted mid-period: all state clears immediately. The sequence restarts with a marker and BIP is not carried over.
- All lanes' markers are emitted in the same cycle. There is no lane skew.

## Configuration
- `PCS_AM_BIP_EN` defined:
  - Per-lane BIP accumulators are built.
  - BIP3/BIP7 fields follow the Operation rules.
- `PCS_AM_BIP_EN` undefined:
  - No accumulators are synthesised.
  - The BIP3 octet is 8'h00 and the BIP7 octet is 8'hFF in every marker.
  - All other behaviour is identical.

## Structure
- `pcs_am_pkg` holds:
  - The 20-entry lane-marker constant array (M0, M1, M2 per lane).
  - `SYNC_CTRL`=2'b10 and `SYNC_DATA`=2'b01.
  - The BIP3 block-parity function.
  - The marker-assembly function (lane marker + BIP3 → 64b payload).
- One sub-module, `pcs_am_bip`:
  - One instance per lane via generate.
  - Holds an 8-bit accumulator with a reload-on-marker input.
  - Compiled only under `PCS_AM_BIP_EN`.

## Test plan
- Reset release with `LANE_N`=4, `AM_PERIOD`=4, `PCS_AM_BIP_EN` undefined:
  - First output has `am_v_o`=1.
  - Lane0 payload = 64'hFF_B8_89_6F_00_47_76_90.
  - Lane1 M0..M2 = F0, C4, E6.
  - `head_o`=2'b10 on all lanes.
- Same configuration, drive lane-indexed incrementing data:
  - `ready_o` pattern is 0,1,1,1,1,0,…
  - Exactly 4 data blocks appear between markers, unmodified and in order, each one cycle after acceptance.
- Hold the input constant while `ready_o`=0:
  - The held block is output after the marker.
  - No block is lost or duplicated.
- `PCS_AM_BIP_EN` defined, all-zero data with `head_i`=2'b01:
  - Second marker BIP3 = parity(first marker) ^ 4× parity(block 01,0).
  - The expected value is computed by the bench model.
  - BIP7 = ~BIP3.
- Assert `nreset` low for one cycle at `cnt`=2:
  - Outputs clear.
  - The next output is a marker with BIP3=8'h00.
  - The period restarts.
- `LANE_N`=20, `AM_PERIOD`=2:
  - All 20 lanes carry their table markers in the same cycle.
  - The period is 3 cycles.

Source files
------------

// File: rtl/pcs_am_pkg.sv
// -----------------------------------------------------------------------------
// pcs_am_pkg
// Shared constants and helpers for the PCS alignment-marker inserter:
//   - LANE_MARKERS : 20-entry lane-marker table (M0, M1, M2 per lane)
//   - SYNC_CTRL / SYNC_DATA : 66b sync header codes
//   - bip3_parity() : 8-bit BIP3 contribution of one 66b block
//   - am_payload()  : 64b marker payload from a lane marker and its BIP3
// -----------------------------------------------------------------------------
package pcs_am_pkg;

  localparam int LANE_MAX = 20;

  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [1:0] SYNC_DATA = 2'b01;

  typedef struct packed {
    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] m2;
  } lane_marker_t;

  // Lanes 0..3 carry the 40GBASE-R markers so a 4-lane build is a native 40G
  // PCS; lanes 4..19 carry the 100GBASE-R markers for the wide build.
  localparam lane_marker_t LANE_MARKERS [LANE_MAX] = '{
    '{8'h90, 8'h76, 8'h47}, '{8'hF0, 8'hC4, 8'hE6},
    '{8'hC5, 8'h65, 8'h9B}, '{8'hA2, 8'h79, 8'h3D},
    '{8'hF5, 8'h07, 8'h09}, '{8'hDD, 8'h14, 8'hC2},
    '{8'h9A, 8'h4A, 8'h26}, '{8'h7B, 8'h45, 8'h66},
    '{8'hA0, 8'h24, 8'h76}, '{8'h68, 8'hC9, 8'hFB},
    '{8'hFD, 8'h6C, 8'h99}, '{8'hB9, 8'h91, 8'h55},
    '{8'h5C, 8'hB9, 8'hB2}, '{8'h1A, 8'hF8, 8'hBD},
    '{8'h83, 8'hC7, 8'hCA}, '{8'h35, 8'h36, 8'hCD},
    '{8'hC4, 8'h31, 8'h4C}, '{8'hAD, 8'hD6, 8'hB7},
    '{8'h5F, 8'h66, 8'h2A}, '{8'hC0, 8'hF0, 8'hE5}
  };

  // 66b bit j (j=0 is head[0], the first header bit on the wire) lands in
  // parity bit 3 for j=0, bit 4 for j=1, and bit (j-2) mod 8 for payload bits,
  // so the payload reduces to an XOR of its eight octets.
  function automatic logic [7:0] bip3_parity(input logic [1:0]  head,
                                             input logic [63:0] data);
    logic [7:0] p;
    p = 8'h00;
    for (int o = 0; o < 8; o++) p ^= data[8*o +: 8];
    p[3] ^= head[0];
    p[4] ^= head[1];
    return p;
  endfunction

  // Octet 0 sits in bits [7:0]: M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3.
  function automatic logic [63:0] am_payload(input lane_marker_t m,
                                             input logic [7:0]   bip3);
    return {~bip3, ~m.m2, ~m.m1, ~m.m0, bip3, m.m2, m.m1, m.m0};
  endfunction

endpackage

// File: rtl/pcs_am_bip.sv
// -----------------------------------------------------------------------------
// pcs_am_bip
// Per-lane BIP3 accumulator. Only compiled when PCS_AM_BIP_EN is defined.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   i_reload    : this cycle's output block is a marker (reload accumulator)
//   i_head      : 2b sync header of the block being output this cycle
//   i_data      : 64b payload of the block being output this cycle
//   o_bip3      : running parity since (and including) the previous marker
// -----------------------------------------------------------------------------
`ifdef PCS_AM_BIP_EN
module pcs_am_bip
  import pcs_am_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_reload,
  input  logic [1:0]  i_head,
  input  logic [63:0] i_data,
  output logic [7:0]  o_bip3
);

  logic [7:0] r_acc;
  logic [7:0] w_par;

  assign w_par = bip3_parity(i_head, i_data);

  // A marker restarts the window with its own parity; the BIP3 it carries was
  // taken from r_acc before this edge, so there is no combinational loop.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)       r_acc <= 8'h00;
    else if (i_reload) r_acc <= w_par;
    else               r_acc <= r_acc ^ w_par;
  end

  assign o_bip3 = r_acc;

endmodule
`endif

// File: rtl/pcs_am_insert.sv
// -----------------------------------------------------------------------------
// pcs_am_insert
// Multi-lane alignment-marker inserter between the 64b/66b encoder and the
// PMA gearbox. Every AM_PERIOD data blocks the encoder is stalled for one
// cycle and a marker is emitted on all lanes in the same cycle.
// Optional feature macro: PCS_AM_BIP_EN (per-lane BIP3/BIP7 accumulators);
// when undefined, markers carry BIP3=8'h00 / BIP7=8'hFF.
// Parameters:
//   LANE_N    : number of lanes, 1..20
//   AM_PERIOD : data blocks per lane between markers, >= 2
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   head_i      : per-lane sync header, lane x at [2x+1:2x]
//   data_i      : per-lane payload, lane x at [64x+63:64x]
//   ready_o     : inputs consumed this cycle when high
//   head_o      : per-lane sync header to the gearbox (registered)
//   data_o      : per-lane payload to the gearbox (registered)
//   am_v_o      : current output cycle is a marker on all lanes
// -----------------------------------------------------------------------------
module pcs_am_insert
  import pcs_am_pkg::*;
#(
  parameter int LANE_N    = 4,
  parameter int AM_PERIOD = 16383
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [2*LANE_N-1:0]   head_i,
  input  logic [64*LANE_N-1:0]  data_i,
  output logic                  ready_o,
  output logic [2*LANE_N-1:0]   head_o,
  output logic [64*LANE_N-1:0]  data_o,
  output logic                  am_v_o
);

  localparam int CNT_W = $clog2(AM_PERIOD + 1);

  logic [CNT_W-1:0]      r_cnt;
  logic                  w_am;
  logic [2*LANE_N-1:0]   w_head_nxt;
  logic [64*LANE_N-1:0]  w_data_nxt;
  logic [8*LANE_N-1:0]   w_bip3;
  logic [2*LANE_N-1:0]   r_head;
  logic [64*LANE_N-1:0]  r_data;
  logic                  r_am_v;

  // Marker slot is cnt==0; ready is decoded purely from the register so the
  // encoder stall has no combinational path from the inputs.
  assign w_am    = (r_cnt == '0);
  assign ready_o = ~w_am;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                          r_cnt <= '0;
    else if (r_cnt == CNT_W'(AM_PERIOD))  r_cnt <= '0;
    else                                  r_cnt <= r_cnt + CNT_W'(1);
  end

  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
`ifdef PCS_AM_BIP_EN
    pcs_am_bip u_bip (
      .clk      (clk),
      .nreset   (nreset),
      .i_reload (w_am),
      .i_head   (w_head_nxt[2*g +: 2]),
      .i_data   (w_data_nxt[64*g +: 64]),
      .o_bip3   (w_bip3[8*g +: 8])
    );
`else
    assign w_bip3[8*g +: 8] = 8'h00;
`endif

    assign w_head_nxt[2*g +: 2]   = w_am ? SYNC_CTRL : head_i[2*g +: 2];
    assign w_data_nxt[64*g +: 64] = w_am ? am_payload(LANE_MARKERS[g], w_bip3[8*g +: 8])
                                         : data_i[64*g +: 64];
  end

  // NOTE: the output datapath registers are reset too, because the gearbox
  // must see all-zero outputs and am_v_o=0 while nreset is low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_head <= '0;
      r_data <= '0;
      r_am_v <= 1'b0;
    end else begin
      r_head <= w_head_nxt;
      r_data <= w_data_nxt;
      r_am_v <= w_am;
    end
  end

  assign head_o = r_head;
  assign data_o = r_data;
  assign am_v_o = r_am_v;

endmodule

// File: tb/tb_pcs_am_insert.sv
// -----------------------------------------------------------------------------
// tb_pcs_am_insert
// Two instances: A (LANE_N=4, AM_PERIOD=4) and B (LANE_N=20, AM_PERIOD=2).
// Expected markers come from the bench's own lane table and parity model;
// the BIP model follows PCS_AM_BIP_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_pcs_am_insert;

  localparam int LA = 4;
  localparam int PA = 4;
  localparam int LB = 20;
  localparam int PB = 2;
  localparam int CW = 1280;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               nreset_a, nreset_b;
  logic [2*LA-1:0]    head_a,  head_oa;
  logic [64*LA-1:0]   data_a,  data_oa;
  logic               ready_a, am_a;
  logic [2*LB-1:0]    head_b,  head_ob;
  logic [64*LB-1:0]   data_b,  data_ob;
  logic               ready_b, am_b;

  pcs_am_insert #(.LANE_N(LA), .AM_PERIOD(PA)) u_dut_a (
    .clk(clk), .nreset(nreset_a), .head_i(head_a), .data_i(data_a),
    .ready_o(ready_a), .head_o(head_oa), .data_o(data_oa), .am_v_o(am_a));

  pcs_am_insert #(.LANE_N(LB), .AM_PERIOD(PB)) u_dut_b (
    .clk(clk), .nreset(nreset_b), .head_i(head_b), .data_i(data_b),
    .ready_o(ready_b), .head_o(head_ob), .data_o(data_ob), .am_v_o(am_b));

  int n_checks = 0;
  int n_fail   = 0;

  // {M0, M1, M2} per lane, M0 in the top byte.
  logic [23:0] am_tab [20] = '{
    24'h907647, 24'hF0C4E6, 24'hC5659B, 24'hA2793D, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};

  logic [7:0] acc_a [LA];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_par(input logic [1:0] h, input logic [63:0] d);
    logic [7:0] p;
    logic       b;
    int         pos;
    p = 8'h00;
    for (int j = 0; j < 66; j++) begin
      if (j == 0)      begin b = h[0];     pos = 3; end
      else if (j == 1) begin b = h[1];     pos = 4; end
      else             begin b = d[j-2];   pos = (j - 2) % 8; end
      p[pos] = p[pos] ^ b;
    end
    return p;
  endfunction

  function automatic logic [63:0] exp_marker(input int lane, input logic [7:0] bip);
    logic [23:0] m;
    logic [63:0] r;
    m = am_tab[lane];
    r[7:0]   = m[23:16];  r[15:8]  = m[15:8];  r[23:16] = m[7:0];  r[31:24] = bip;
    r[39:32] = ~m[23:16]; r[47:40] = ~m[15:8]; r[55:48] = ~m[7:0]; r[63:56] = ~bip;
    return r;
  endfunction

  function automatic logic [7:0] bip_a(input int lane);
`ifdef PCS_AM_BIP_EN
    return acc_a[lane];
`else
    return 8'h00 & {8{lane[0]}};
`endif
  endfunction

  function automatic logic [63:0] blk_data(input int b, input int x);
    return {16'hB10C, 8'(x), 8'(b), 32'h1357_9BDF ^ (32'(b) * 32'h0101_0101)};
  endfunction

  function automatic logic [1:0] blk_head(input int b);
    return (b % 3 == 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic drive_a(input int b);
    for (int x = 0; x < LA; x++) begin
      data_a[64*x +: 64] = blk_data(b, x);
      head_a[2*x +: 2]   = blk_head(b);
    end
  endtask

  typedef struct {
    int   blk_in;     // block presented by the encoder before the edge
    logic exp_ready;  // ready_o before the edge
    logic exp_am;     // am_v_o after the edge
    int   exp_blk;    // block expected after the edge (ignored on markers)
  } vec_t;

  vec_t vecs [12];

  logic [2*LA-1:0]  eh;
  logic [64*LA-1:0] ed;
  logic [7:0]       p1, pd, bip2;
  logic [63:0]      mask;
  logic             exp_am_b [7];
  logic             exp_rdy_b [7];

  initial begin
    vecs[0]  = '{0, 1'b0, 1'b1, -1};
    vecs[1]  = '{0, 1'b1, 1'b0,  0};
    vecs[2]  = '{1, 1'b1, 1'b0,  1};
    vecs[3]  = '{2, 1'b1, 1'b0,  2};
    vecs[4]  = '{3, 1'b1, 1'b0,  3};
    vecs[5]  = '{4, 1'b0, 1'b1, -1};
    vecs[6]  = '{4, 1'b1, 1'b0,  4};
    vecs[7]  = '{5, 1'b1, 1'b0,  5};
    vecs[8]  = '{6, 1'b1, 1'b0,  6};
    vecs[9]  = '{7, 1'b1, 1'b0,  7};
    vecs[10] = '{8, 1'b0, 1'b1, -1};
    vecs[11] = '{8, 1'b1, 1'b0,  8};
    exp_am_b  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_rdy_b = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    nreset_a = 1'b0;
    nreset_b = 1'b0;
    head_a = '0; data_a = '0;
    head_b = {LB{2'b01}}; data_b = '0;
    for (int x = 0; x < LA; x++) acc_a[x] = 8'h00;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_ready", ready_a, 0);
    check("rst_am_v", am_a, 0);
    check("rst_head", head_oa, 0);
    check("rst_data", data_oa, 0);
    nreset_a = 1'b1;

    // ---------------- table-driven pass-through / markers ----------------
    for (int k = 0; k < 12; k++) begin
      drive_a(vecs[k].blk_in);
      check($sformatf("v%0d_ready", k), ready_a, vecs[k].exp_ready);
      @(posedge clk); #1;
      for (int x = 0; x < LA; x++) begin
        if (vecs[k].exp_am) begin
          eh[2*x +: 2]  = 2'b10;
          ed[64*x +: 64] = exp_marker(x, bip_a(x));
        end else begin
          eh[2*x +: 2]  = blk_head(vecs[k].exp_blk);
          ed[64*x +: 64] = blk_data(vecs[k].exp_blk, x);
        end
      end
      check($sformatf("v%0d_am_v", k), am_a, vecs[k].exp_am);
      check($sformatf("v%0d_head", k), head_oa, eh);
      check($sformatf("v%0d_data", k), data_oa, ed);
      if (k == 0) begin
        check("first_lane0_payload", data_oa[63:0], 64'hFF_B8_89_6F_00_47_76_90);
        check("first_lane1_m012", data_oa[64 +: 24], 24'hE6_C4_F0);
        check("first_heads_ctrl", head_oa, 8'hAA);
      end
      for (int x = 0; x < LA; x++) begin
        if (vecs[k].exp_am) acc_a[x] = m_par(eh[2*x +: 2], ed[64*x +: 64]);
        else                acc_a[x] = acc_a[x] ^ m_par(eh[2*x +: 2], ed[64*x +: 64]);
      end
      @(negedge clk);
    end

    // ---------------- reset mid-period (cnt==2 here) ----------------
    head_a = {LA{2'b01}};
    data_a = '0;
    nreset_a = 1'b0;
    #1;
    check("midrst_ready", ready_a, 0);
    check("midrst_am_v", am_a, 0);
    check("midrst_head", head_oa, 0);
    check("midrst_data", data_oa, 0);
    @(negedge clk);
    nreset_a = 1'b1;

    // ---------------- restart + BIP over all-zero data ----------------
    pd = m_par(2'b01, 64'h0);
    for (int c = 0; c < 7; c++) begin
      check($sformatf("bip_c%0d_ready", c), ready_a, (c != 0 && c != 5));
      @(posedge clk); #1;
      check($sformatf("bip_c%0d_am_v", c), am_a, (c == 0 || c == 5));
      for (int x = 0; x < LA; x++) begin
        if (c == 0) begin
          eh[2*x +: 2]   = 2'b10;
          ed[64*x +: 64] = exp_marker(x, 8'h00);
        end else if (c == 5) begin
          p1 = m_par(2'b10, exp_marker(x, 8'h00));
`ifdef PCS_AM_BIP_EN
          bip2 = p1 ^ pd ^ pd ^ pd ^ pd;
`else
          bip2 = 8'h00 & p1;
`endif
          eh[2*x +: 2]   = 2'b10;
          ed[64*x +: 64] = exp_marker(x, bip2);
        end else begin
          eh[2*x +: 2]   = 2'b01;
          ed[64*x +: 64] = 64'h0;
        end
      end
      check($sformatf("bip_c%0d_head", c), head_oa, eh);
      check($sformatf("bip_c%0d_data", c), data_oa, ed);
      @(negedge clk);
    end

    // ---------------- 20 lanes, period 3 ----------------
    nreset_b = 1'b1;
    mask = 64'h00FF_FFFF_00FF_FFFF;
    for (int c = 0; c < 7; c++) begin
      check($sformatf("l20_c%0d_ready", c), ready_b, exp_rdy_b[c]);
      @(posedge clk); #1;
      check($sformatf("l20_c%0d_am_v", c), am_b, exp_am_b[c]);
      if (c == 0) begin
        for (int x = 0; x < LB; x++)
          check($sformatf("l20_first_lane%0d", x), data_ob[64*x +: 64], exp_marker(x, 8'h00));
        check("l20_first_heads", head_ob, {LB{2'b10}});
      end
      if (c == 3) begin
        for (int x = 0; x < LB; x++)
          check($sformatf("l20_second_lane%0d_m", x), data_ob[64*x +: 64] & mask,
                exp_marker(x, 8'h00) & mask);
      end
      if (c == 1) check("l20_data_head", head_ob, {LB{2'b01}});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
